bus_arbiter8: RTL and testbench

Round-robin arbiter that shares one 8-way mux8/demux8 datapath between 8 requesters. It grants exactly one requester at a time and drives the mux/demux select lines and the demux data-enable. Each grant is held until the owner drops its request or a hold limit expires. There is a one-cycle dead gap between owners so selects never switch under a live grant.

---
 rtl/bus_arbiter8_pkg.sv | 19 +
 rtl/bus_arbiter8_rr_pick8.sv | 28 ++
 rtl/demux8.sv | 20 ++
 rtl/bus_arbiter8.sv | 120 ++++++++++++
 tb/tb_bus_arbiter8.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter.
package bus_arbiter8_pkg;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arbState_t;

    // Index that lies 'off' positions after 'base', wrapping 7 -> 0.
    function automatic logic [SEL_W-1:0] wrapAdd(input logic [SEL_W-1:0] base,
                                                 input int unsigned off);
        return base + SEL_W'(off);
    endfunction

endpackage

// File: rtl/bus_arbiter8_rr_pick8.sv
// Round-robin winner picker: first set request after ptr, wrapping 7 -> 0.
module rr_pick8
    import bus_arbiter8_pkg::*;
(
    input  logic [0:N-1]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [SEL_W-1:0] w_idx;

    // Walk from the farthest offset down to ptr+1 so the nearest hit wins;
    // offset N lands back on ptr itself, giving the last owner lowest rank.
    always_comb begin
        win   = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int off = N; off >= 1; off--) begin
            w_idx = wrapAdd(ptr, off);
            if (req[w_idx]) begin
                win = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux8.sv
// 1-to-8 demultiplexer: routes input i to output o[k], k = 4*j0 + 2*j1 + j2.
module demux8 (
    input  logic       i,
    input  logic       j0,
    input  logic       j1,
    input  logic       j2,
    output logic [0:7] o
);

    logic [2:0] w_idx;

    assign w_idx = {j0, j1, j2};

    // Drive only the selected output, all others low.
    always_comb begin
        o        = '0;
        o[w_idx] = i;
    end

endmodule

// File: rtl/bus_arbiter8.sv
// 8-way round-robin arbiter driving mux8/demux8 selects, with hold limit
// and a one-cycle dead gap between owners.
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic [0:N-1] req,
    output logic [0:N-1] gnt,
    output logic         sel_j2,
    output logic         sel_j1,
    output logic         sel_j0,
    output logic         valid,
    output logic         timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    arbState_t        r_state;
    arbState_t        w_stateNext;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptrNext;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_selNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_valid;
    logic             w_validNext;
    logic             r_timeout;
    logic             w_timeoutNext;

    logic [SEL_W-1:0] w_win;
    logic             w_any;
    logic [0:N-1]     w_decoded;

    rr_pick8 u_pick (
        .req (req),
        .ptr (r_ptr),
        .win (w_win),
        .any (w_any)
    );

    demux8 u_gntDecode (
        .i  (1'b1),
        .j0 (r_sel[2]),
        .j1 (r_sel[1]),
        .j2 (r_sel[0]),
        .o  (w_decoded)
    );

    // State and output registers; reset parks ptr at 7 so requester 0 leads.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state   <= IDLE;
            r_ptr     <= SEL_W'(N - 1);
            r_sel     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_ptr     <= w_ptrNext;
            r_sel     <= w_selNext;
            r_cnt     <= w_cntNext;
            r_valid   <= w_validNext;
            r_timeout <= w_timeoutNext;
        end
    end

    // Next-state logic: arbitrate from IDLE/GAP, hold or release from GRANT.
    always_comb begin
        w_stateNext   = r_state;
        w_ptrNext     = r_ptr;
        w_selNext     = r_sel;
        w_cntNext     = r_cnt;
        w_validNext   = r_valid;
        w_timeoutNext = 1'b0;
        unique case (r_state)
            IDLE, GAP: begin
                if (w_any) begin
                    w_stateNext = GRANT;
                    w_ptrNext   = w_win;
                    w_selNext   = w_win;
                    w_cntNext   = '0;
                    w_validNext = 1'b1;
                end else begin
                    w_stateNext = IDLE;
                    w_validNext = 1'b0;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    w_stateNext = GAP;
                    w_validNext = 1'b0;
                end else if (r_cnt == HOLD_LIMIT) begin
                    w_stateNext   = GAP;
                    w_validNext   = 1'b0;
                    w_timeoutNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_validNext = 1'b0;
            end
        endcase
    end

    assign gnt     = w_decoded & {N{r_valid}};
    assign valid   = r_valid;
    assign timeout = r_timeout;
    assign sel_j0  = r_sel[2];
    assign sel_j1  = r_sel[1];
    assign sel_j2  = r_sel[0];

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed self-checking bench for bus_arbiter8 with MAX_HOLD=4.
module tb_bus_arbiter8;

    logic       clk;
    logic       reset_;
    logic [0:7] req;
    logic [0:7] gnt;
    logic       sel_j2;
    logic       sel_j1;
    logic       sel_j0;
    logic       valid;
    logic       timeout;

    int  assertCount;
    int  failCount;
    bit  monitorOn;

    bus_arbiter8 #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk     (clk),
        .reset_  (reset_),
        .req     (req),
        .gnt     (gnt),
        .sel_j2  (sel_j2),
        .sel_j1  (sel_j1),
        .sel_j0  (sel_j0),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:7] oh(input int k);
        logic [0:7] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Drive a request vector, then let exactly one rising edge sample it.
    task automatic applyStimulus(input logic [0:7] r);
        req = r;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [0:7] expGnt,
                               input logic [2:0] expSel, input logic expTimeout);
        logic [2:0] obsSel;
        obsSel = {sel_j0, sel_j1, sel_j2};
        assertCount++;
        assert (gnt === expGnt) else begin
            failCount++;
            $error("[TB] FAIL %s gnt: observed %b expected %b", tag, gnt, expGnt);
        end
        assertCount++;
        assert (valid === (|expGnt)) else begin
            failCount++;
            $error("[TB] FAIL %s valid: observed %b expected %b", tag, valid, |expGnt);
        end
        assertCount++;
        assert (obsSel === expSel) else begin
            failCount++;
            $error("[TB] FAIL %s sel: observed %0d expected %0d", tag, obsSel, expSel);
        end
        assertCount++;
        assert (timeout === expTimeout) else begin
            failCount++;
            $error("[TB] FAIL %s timeout: observed %b expected %b", tag, timeout, expTimeout);
        end
    endtask

    // Invariant watch on every falling edge: one-hot grant, valid/gnt/sel
    // agreement, sel stable under a live grant, no back-to-back timeout.
    logic [2:0] prevSel;
    logic       prevValid;
    logic       prevTimeout;
    always @(negedge clk) begin
        if (!reset_ || !monitorOn) begin
            prevValid   = 1'b0;
            prevTimeout = 1'b0;
            prevSel     = '0;
        end else begin
            assertCount++;
            assert ($onehot0(gnt) && (valid === (|gnt))) else begin
                failCount++;
                $error("[TB] FAIL inv_onehot: observed gnt %b valid %b", gnt, valid);
            end
            if (valid) begin
                assertCount++;
                assert (gnt[{sel_j0, sel_j1, sel_j2}] === 1'b1) else begin
                    failCount++;
                    $error("[TB] FAIL inv_selmatch: observed gnt %b sel %0d", gnt, {sel_j0, sel_j1, sel_j2});
                end
                if (prevValid) begin
                    assertCount++;
                    assert ({sel_j0, sel_j1, sel_j2} === prevSel) else begin
                        failCount++;
                        $error("[TB] FAIL inv_selstable: observed %0d expected %0d", {sel_j0, sel_j1, sel_j2}, prevSel);
                    end
                end
            end
            assertCount++;
            assert (!(prevTimeout && timeout)) else begin
                failCount++;
                $error("[TB] FAIL inv_timeout2: observed timeout %b after %b expected not both high", timeout, prevTimeout);
            end
            prevValid   = valid;
            prevTimeout = timeout;
            prevSel     = {sel_j0, sel_j1, sel_j2};
        end
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        monitorOn   = 1'b1;
        reset_      = 1'b0;
        req         = '0;

        // Reset state.
        #7;
        checkOutput("reset", '0, 3'd0, 1'b0);
        @(negedge clk);
        reset_ = 1'b1;

        // Single request from requester 2, one-cycle latency.
        applyStimulus(oh(2));
        checkOutput("single_grant", oh(2), 3'd2, 1'b0);
        applyStimulus(oh(2));
        checkOutput("single_hold", oh(2), 3'd2, 1'b0);
        applyStimulus('0);
        checkOutput("single_gap", '0, 3'd2, 1'b0);
        applyStimulus('0);
        checkOutput("single_idle_sel_kept", '0, 3'd2, 1'b0);

        // Re-reset so the rotation starts at requester 0.
        reset_ = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;

        // Rotation: all request, each owner drops after 3 grant cycles.
        for (int n = 0; n < 9; n++) begin
            int k;
            k = n % 8;
            applyStimulus(8'hFF);
            checkOutput("rot_grant", oh(k), 3'(k), 1'b0);
            applyStimulus(8'hFF);
            checkOutput("rot_hold2", oh(k), 3'(k), 1'b0);
            applyStimulus(8'hFF);
            checkOutput("rot_hold3", oh(k), 3'(k), 1'b0);
            applyStimulus(8'hFF & ~oh(k));
            checkOutput("rot_gap", '0, 3'(k), 1'b0);
        end

        // Forced release: sole requester 5 times out and is re-granted.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(oh(5));
                checkOutput("limit_hold", oh(5), 3'd5, 1'b0);
            end
            applyStimulus(oh(5));
            checkOutput("limit_timeout", '0, 3'd5, 1'b1);
        end

        // Fairness: 2 and 6 alternate after timeouts (last owner was 5, so 6 leads).
        for (int r = 0; r < 4; r++) begin
            int k;
            k = (r % 2 == 0) ? 6 : 2;
            for (int c = 0; c < 4; c++) begin
                applyStimulus(oh(2) | oh(6));
                checkOutput("fair_hold", oh(k), 3'(k), 1'b0);
            end
            applyStimulus(oh(2) | oh(6));
            checkOutput("fair_timeout", '0, 3'(k), 1'b1);
        end
        applyStimulus('0);
        checkOutput("fair_idle", '0, 3'd2, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 3.
        applyStimulus(oh(3));
        checkOutput("async_pre", oh(3), 3'd3, 1'b0);
        #2;
        reset_ = 1'b0;
        #1;
        checkOutput("async_reset", '0, 3'd0, 1'b0);
        @(negedge clk);
        reset_ = 1'b1;
        applyStimulus(oh(0) | oh(3));
        checkOutput("async_first0", oh(0), 3'd0, 1'b0);
        applyStimulus(oh(0) | oh(3));
        checkOutput("async_hold0", oh(0), 3'd0, 1'b0);
        applyStimulus(oh(3));
        checkOutput("async_gap", '0, 3'd0, 1'b0);
        applyStimulus(oh(3));
        checkOutput("async_then3", oh(3), 3'd3, 1'b0);

        // Release on the same edge the hold limit is reached: no timeout.
        applyStimulus(oh(3));
        checkOutput("same_hold2", oh(3), 3'd3, 1'b0);
        applyStimulus(oh(3));
        checkOutput("same_hold3", oh(3), 3'd3, 1'b0);
        applyStimulus(oh(3));
        checkOutput("same_hold4", oh(3), 3'd3, 1'b0);
        applyStimulus('0);
        checkOutput("same_release", '0, 3'd3, 1'b0);
        applyStimulus('0);
        checkOutput("same_idle", '0, 3'd3, 1'b0);

        monitorOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
